// File: rtl/tdc_sequencer.sv
// ----------------------------------------------------------------------------
// tdc_sequencer
//   Burst controller for the TDC core. A start command latches a burst length
//   and a per-measurement timeout. Each measurement then runs
//   ARM -> WAIT -> OUT: pulse tdc_arm, wait for the TDC strobe or for the
//   timer to expire, then present the result on a valid/ready port.
//
//   Ports:
//     clk, rst_n        100 MHz clock, asynchronous active-low reset
//     start             one-cycle command, accepted only while idle
//     burst_len         measurements per burst (0 -> 1), sampled on start
//     timeout           cycles allowed per measurement (0 -> 1), sampled on start
//     abort             cancels the burst from any busy state
//     tdc_arm/tdc_clr   one-cycle arm / clear pulses to the TDC
//     tdc_measurement   TDC result {6'b0, coarse[27:0], fine[5:0]}
//     tdc_meas_valid    one-cycle TDC result strobe
//     res_data/res_timeout/res_valid/res_ready   result port
//     busy, done        activity flag and end-of-burst pulse
//     tmo_count         timeouts seen in the current/last burst
//
//   Build option TDC_SEQ_AVG_EN: instead of one result per measurement, the
//   non-timed-out measurements are summed and a single saturated result is
//   emitted at the end of the burst.
//
//   Timeout timing: with timeout T and the ARM cycle at A, the last counting
//   cycle is A+T (a strobe there still wins). tdc_clr is issued at A+T+1,
//   a cycle in which late strobes are ignored, and the timeout result
//   appears at A+T+2.
// ----------------------------------------------------------------------------
module tdc_sequencer #(
   parameter int BURST_W = 8,
   parameter int TMO_W   = 28
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [TMO_W-1:0]   timeout,
   input  logic               abort,
   output logic               tdc_arm,
   output logic               tdc_clr,
   input  logic [39:0]        tdc_measurement,
   input  logic               tdc_meas_valid,
   output logic [39:0]        res_data,
   output logic               res_timeout,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] tmo_count
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_OUT} state_t;

   state_t             state_q, state_d;
   logic [BURST_W-1:0] remaining_q, remaining_d, tmo_count_d;
   logic [TMO_W-1:0]   tmo_len_q, tmo_len_d, timer_q, timer_d;
   logic [39:0]        res_data_d, meas_val;
   logic               res_timeout_d, clr_d, done_d, meas_end, meas_tmo;
`ifdef TDC_SEQ_AVG_EN
   logic [47:0]        sum_q, sum_d;
   logic               all_tmo_q, all_tmo_d;
`endif

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      tmo_len_d     = tmo_len_q;
      timer_d       = timer_q;
      tmo_count_d   = tmo_count;
      res_data_d    = res_data;
      res_timeout_d = res_timeout;
      clr_d         = 1'b0;
      done_d        = 1'b0;
      meas_end      = 1'b0;
      meas_tmo      = 1'b0;
      meas_val      = '0;
`ifdef TDC_SEQ_AVG_EN
      sum_d         = sum_q;
      all_tmo_d     = all_tmo_q;
`endif
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         done_d  = 1'b1;
         clr_d   = (state_q == S_ARM) || (state_q == S_WAIT);
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               state_d     = S_ARM;
               remaining_d = (burst_len == '0) ? BURST_W'(1) : burst_len;
               tmo_len_d   = (timeout == '0) ? TMO_W'(1) : timeout;
               tmo_count_d = '0;
`ifdef TDC_SEQ_AVG_EN
               sum_d       = '0;
               all_tmo_d   = 1'b1;
`endif
            end
            S_ARM: begin
               timer_d = tmo_len_q;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // timer_q == 0 marks the clearing cycle after expiry
               if (timer_q == '0) begin
                  meas_end = 1'b1;
                  meas_tmo = 1'b1;
                  if (tmo_count != '1) tmo_count_d = tmo_count + BURST_W'(1);
               end else if (tdc_meas_valid) begin
                  meas_end = 1'b1;
                  meas_val = tdc_measurement;
               end else begin
                  timer_d = timer_q - TMO_W'(1);
                  clr_d   = (timer_q == TMO_W'(1));
               end
               if (meas_end) begin
`ifdef TDC_SEQ_AVG_EN
                  sum_d     = sum_q + {8'd0, meas_val};
                  all_tmo_d = all_tmo_q & meas_tmo;
                  if (remaining_q == BURST_W'(1)) begin
                     state_d       = S_OUT;
                     res_data_d    = (sum_d[47:40] != '0) ? {40{1'b1}} : sum_d[39:0];
                     res_timeout_d = all_tmo_d;
                  end else begin
                     remaining_d = remaining_q - BURST_W'(1);
                     state_d     = S_ARM;
                  end
`else
                  state_d       = S_OUT;
                  res_data_d    = meas_val;
                  res_timeout_d = meas_tmo;
`endif
               end
            end
            S_OUT: if (res_ready) begin
`ifdef TDC_SEQ_AVG_EN
               done_d  = 1'b1;
               state_d = S_IDLE;
`else
               if (remaining_q == BURST_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  remaining_d = remaining_q - BURST_W'(1);
                  state_d     = S_ARM;
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         tmo_len_q   <= '0;
         timer_q     <= '0;
         tdc_arm     <= 1'b0;
         tdc_clr     <= 1'b0;
         res_data    <= '0;
         res_timeout <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         tmo_count   <= '0;
`ifdef TDC_SEQ_AVG_EN
         sum_q       <= '0;
         all_tmo_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         tmo_len_q   <= tmo_len_d;
         timer_q     <= timer_d;
         tdc_arm     <= (state_d == S_ARM);
         tdc_clr     <= clr_d;
         res_data    <= res_data_d;
         res_timeout <= res_timeout_d;
         res_valid   <= (state_d == S_OUT);
         busy        <= (state_d != S_IDLE);
         done        <= done_d;
         tmo_count   <= tmo_count_d;
`ifdef TDC_SEQ_AVG_EN
         sum_q       <= sum_d;
         all_tmo_q   <= all_tmo_d;
`endif
      end
   end

endmodule

// File: doc/tdc_sequencer.md
# tdc_sequencer

Burst controller for the TDC core. It accepts a start command with a burst length and a per-measurement timeout. It then arms the TDC once per measurement and waits for each result, or clears the TDC on timeout. Each result is presented on a valid/ready output port that feeds the readout path (UART framer / FIFO). It sits between the host command decoder and the TDC core, on the 100 MHz domain.

## Interface
Parameters:
- BURST_W, 8: width of burst length and timeout counter.
- TMO_W, 28: width of per-measurement timeout (cycles).

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command; accepted only in IDLE.
- burst_len  in  BURST_W  measurements per burst, sampled on accepted start; 0 treated as 1.
- timeout  in  TMO_W  cycles allowed per measurement, sampled on accepted start; 0 treated as 1.
- abort  in  1  cancels the burst from any state.
- tdc_arm  out  1  one-cycle arm pulse to the TDC.
- tdc_clr  out  1  one-cycle synchronous clear to the TDC state machine.
- tdc_measurement  in  40  TDC result {6'b0, coarse[27:0], fine[5:0]}.
- tdc_meas_valid  in  1  one-cycle TDC result strobe.
- res_data  out  40  result word.
- res_timeout  out  1  result qualifier: measurement timed out; res_data = 0.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at burst end (normal or aborted).
- tmo_count  out  BURST_W  timeouts in the last or current burst; cleared on accepted start.

## Operation
- Reset values: all outputs 0; state IDLE; internal counters 0.
- States: IDLE, ARM, WAIT, OUT.
- IDLE: start → latch burst_len and timeout, clear tmo_count, go ARM. Otherwise hold.
- ARM: tdc_arm=1 for exactly this cycle, load the timer with timeout, go WAIT.
- WAIT: timer decrements each cycle.
  - tdc_meas_valid → res_data=tdc_measurement, res_timeout=0, go OUT.
  - Timer reaches 0 with no strobe → tdc_clr pulse, res_data=0, res_timeout=1, tmo_count+1 (saturating), go OUT.
  - Strobe and expiry in the same cycle → the measurement wins.
- OUT: res_valid=1; res_data and res_timeout held stable until res_ready.
  - On the valid&ready cycle: decrement remaining.
  - remaining was 1 → done pulse, go IDLE.
  - Otherwise go ARM.
- tdc_meas_valid outside WAIT is ignored (late result after timeout/clear).
- start outside IDLE is ignored.
- abort (highest priority, any non-IDLE state):
  - go IDLE, res_valid=0, done pulse.
  - tdc_clr pulse if the state was ARM or WAIT.
  - abort in IDLE has no effect.

## Timing
- start at cycle N → busy and state ARM at N+1, tdc_arm high at N+1 only.
- tdc_meas_valid at cycle M in WAIT → res_valid high at M+1.
- Timeout of T → res_valid with res_timeout at N+2+T (N = ARM cycle).
- Handshake: a result is transferred on the clock edge where res_valid and res_ready are both high. The next tdc_arm occurs on the following cycle.
- Minimum per-measurement period with res_ready tied high: 3 cycles plus TDC latency.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- TDC_SEQ_AVG_EN defined:
  - No per-measurement results are emitted.
  - Non-timed-out measurements are accumulated into a 48-bit sum.
  - At burst end, one result is emitted: res_data = sum saturated to 40'hFF_FFFF_FFFF.
  - res_timeout=1 iff every measurement timed out.
  - done pulses on the handshake of that single result.
  - The host divides by (burst_len - tmo_count).
- Undefined: one result per measurement, as described above.

## Test plan
- Reset mid-WAIT: assert rst_n=0 → all outputs 0, state IDLE; a start after release is accepted normally.
- burst_len=3, timeout=1000, TDC returns 0x0000001234 after 50 cycles, res_ready=1 → three tdc_arm pulses, three results 0x0000001234 with res_timeout=0, one done pulse, tmo_count=0.
- burst_len=2, timeout=20, no TDC strobe → tdc_clr 21 cycles after each arm, two results with res_data=0 and res_timeout=1, tmo_count=2.
- res_ready held low 100 cycles → res_valid and res_data stable for the whole stall, no second tdc_arm until the handshake.
- Strobe on the expiry cycle → result reported as a measurement, tmo_count unchanged, no tdc_clr.
- abort in WAIT of burst 5 → tdc_clr and done on the next cycle, busy=0, later strobes ignored.
- With TDC_SEQ_AVG_EN: burst of 4 returning 10, 20, timeout, 30 → single result 60, res_timeout=0, tmo_count=1.
